bdm_block_sequencer: RTL and testbench
======================================

BDM_BLOCK_SEQUENCER -- requirements
Module: bdm_block_sequencer

Interface
REQ-001 SHALL have parameter DELAY_TICKS, default 8'd16, data byte of every generated DELAY word.
REQ-002 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_valid  in  1 / req_ready  out  1  block-request handshake.
REQ-005 SHALL have ports: req_op  in  1  0=read block, 1=write block.
REQ-006 SHALL have ports: req_addr  in  16  start address / req_len  in  8  byte count, 0 means 256.
REQ-007 SHALL have ports: wdata  in  8 / wdata_valid  in  1 / wdata_ready  out  1  write-byte stream.
REQ-008 SHALL have ports: cmd_word  out  16 / cmd_valid  out  1 / cmd_ready  in  1  command-FIFO word stream; cmd_ready is driven as not-full.
REQ-009 SHALL have ports: abort  in  1  cancel current block.
REQ-010 SHALL have ports: busy  out  1 / done  out  1  one-cycle completion pulse / bytes_done  out  9  bytes fully issued.

Function
REQ-011 SHALL format every cmd_word as {3'b000, cmd[4:0], data[7:0]}, with cmd codes WRITE=2, READ=1, DELAY=6.
REQ-012 SHALL transfer a word only on a cycle with cmd_valid && cmd_ready.
REQ-013 SHALL hold cmd_word and cmd_valid stable while cmd_valid && !cmd_ready.
REQ-014 SHALL implement states IDLE, OPC, AHI, ALO, WDAT, DLY, RD, NEXT.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted on req_valid && req_ready.
REQ-016 On acceptance, SHALL latch op, addr and len (0 mapped to 9'd256), clear bytes_done, and enter OPC.
REQ-017 For read blocks, SHALL emit per byte: WRITE 0xE0, WRITE addr[15:8], WRITE addr[7:0], DELAY DELAY_TICKS, READ 0x00.
REQ-018 For write blocks, SHALL emit per byte: WRITE 0xC0, WRITE addr[15:8], WRITE addr[7:0], WRITE wdata, DELAY DELAY_TICKS.
REQ-019 In WDAT, SHALL drive cmd_valid = wdata_valid, cmd_word data = wdata, and wdata_ready = cmd_ready; wdata_ready SHALL be 0 in all other states.
REQ-020 Each state SHALL advance only on its word transfer.
REQ-021 On the final word of a byte, SHALL enter NEXT, increment bytes_done, and increment addr modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-022 NEXT SHALL present no word (cmd_valid=0) for exactly one cycle.
REQ-023 From NEXT, SHALL go to OPC if bytes_done < len; otherwise it SHALL go to IDLE and pulse done for one cycle.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 Abort from a non-IDLE state SHALL force IDLE on the next cycle and SHALL NOT pulse done.
REQ-026 On abort, a word transferred in the same cycle SHALL count as issued; bytes_done SHALL increment only if that word completes a byte.
REQ-027 Abort in IDLE SHALL be ignored, and a req_valid present in the same cycle SHALL still be accepted.
REQ-028 Minimum cost per byte SHALL be 6 cycles with cmd_ready held at 1: 5 word cycles plus NEXT.

Reset
REQ-029 While rst=1, SHALL force state IDLE, cmd_valid=0, cmd_word=0, wdata_ready=0, done=0, busy=0, bytes_done=0, and clear all latched request fields.
REQ-030 Reset mid-block SHALL discard the block without a done pulse; req_ready SHALL be 1 on the first cycle after rst deasserts.

Verification
REQ-031 Read, addr=0x1234, len=1, cmd_ready=1 -> words 0x02E0, 0x0212, 0x0234, 0x0610, 0x0100; done pulses 6 cycles after acceptance; bytes_done=1.
REQ-032 Write, addr=0xFFFF, len=2, wdata 0xAA then 0x55 -> second byte uses address words 0x0200, 0x0200; data words 0x02AA, 0x0255; bytes_done=2.
REQ-033 Read with len=0 -> 256 × 5 = 1280 words issued, bytes_done=256, exactly one done pulse.
REQ-034 Random cmd_ready and wdata_valid stalls -> no word changes while stalled; word sequence identical to the no-stall run.
REQ-035 Abort asserted during the ALO transfer of byte 3 -> IDLE next cycle, no done pulse, bytes_done=2; a new request is accepted immediately.
REQ-036 rst pulsed during DLY -> all outputs at reset values; next request starts from OPC with bytes_done=0.

Source files
------------

// File: rtl/bdm_block_sequencer.sv
// bdm_block_sequencer
// Expands one block request (read or write, 1..256 bytes) into a stream of
// 16-bit command words for a BDM command FIFO. Each byte becomes five words:
//   read : WRITE 0xE0, WRITE addr_hi, WRITE addr_lo, DELAY ticks, READ 0x00
//   write: WRITE 0xC0, WRITE addr_hi, WRITE addr_lo, WRITE wdata, DELAY ticks
// followed by one idle NEXT cycle. Word format is {3'b000, cmd[4:0], data[7:0]}.
//
// Handshakes (all three streams): a beat moves on a rising clk edge where
// valid && ready are both high. A producer holding valid high keeps its
// payload unchanged until the beat moves; ready may change freely.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid / req_ready     block request; req_ready is high only in IDLE
//   req_op                    0 = read block, 1 = write block
//   req_addr, req_len         start address, byte count (0 means 256)
//   wdata / wdata_valid / wdata_ready   write-byte stream (used in WDAT)
//   cmd_word / cmd_valid / cmd_ready    command word stream to the FIFO
//   abort                     cancel the current block (ignored in IDLE)
//   busy, done                busy outside IDLE; done pulses at block end
//   bytes_done                bytes fully issued in the current block
//   dbg_state                 FSM state encoding for observation
module bdm_block_sequencer #(
    parameter logic [7:0] DELAY_TICKS = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic [7:0]  wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [15:0] cmd_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [8:0]  bytes_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OPC  = 3'd1,
        AHI  = 3'd2,
        ALO  = 3'd3,
        WDAT = 3'd4,
        DLY  = 3'd5,
        RD   = 3'd6,
        NEXT = 3'd7
    } state_t;

    localparam logic [4:0] CMD_READ  = 5'd1;
    localparam logic [4:0] CMD_WRITE = 5'd2;
    localparam logic [4:0] CMD_DELAY = 5'd6;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  cnt_q, cnt_d;

    logic [4:0]  cmd;
    logic [7:0]  dat;
    logic        xfer;
    logic        last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            addr_q  <= 16'd0;
            len_q   <= 9'd0;
            cnt_q   <= 9'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        cmd         = 5'd0;
        dat         = 8'd0;
        cmd_valid   = 1'b0;
        wdata_ready = 1'b0;
        req_ready   = 1'b0;
        done        = 1'b0;
        last_word   = 1'b0;
        xfer        = 1'b0;

        // Word presented in each state. All payloads come from registers
        // (or from the held wdata), so a stalled word never changes.
        case (state_q)
            IDLE: req_ready = 1'b1;
            OPC: begin
                cmd       = CMD_WRITE;
                dat       = op_q ? 8'hC0 : 8'hE0;
                cmd_valid = 1'b1;
            end
            AHI: begin
                cmd       = CMD_WRITE;
                dat       = addr_q[15:8];
                cmd_valid = 1'b1;
            end
            ALO: begin
                cmd       = CMD_WRITE;
                dat       = addr_q[7:0];
                cmd_valid = 1'b1;
            end
            WDAT: begin
                // Data byte passes straight through; the word is valid only
                // while a byte is offered, and the byte is consumed only when
                // the FIFO takes the word.
                cmd         = CMD_WRITE;
                dat         = wdata;
                cmd_valid   = wdata_valid;
                wdata_ready = cmd_ready;
            end
            DLY: begin
                cmd       = CMD_DELAY;
                dat       = DELAY_TICKS;
                cmd_valid = 1'b1;
                last_word = op_q;       // DELAY ends a write byte
            end
            RD: begin
                cmd       = CMD_READ;
                dat       = 8'h00;
                cmd_valid = 1'b1;
                last_word = 1'b1;       // READ ends a read byte
            end
            NEXT: done = (cnt_q >= len_q) && !abort;
            default: ;
        endcase

        xfer = cmd_valid && cmd_ready;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    len_d   = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
                    cnt_d   = 9'd0;
                    state_d = OPC;
                end
            end
            OPC:  if (xfer) state_d = AHI;
            AHI:  if (xfer) state_d = ALO;
            ALO:  if (xfer) state_d = op_q ? WDAT : DLY;
            WDAT: if (xfer) state_d = DLY;
            DLY:  if (xfer) state_d = op_q ? NEXT : RD;
            RD:   if (xfer) state_d = NEXT;
            NEXT: state_d = (cnt_q < len_q) ? OPC : IDLE;
            default: state_d = IDLE;
        endcase

        // A completed byte is counted even if abort lands in the same cycle.
        if (xfer && last_word) begin
            cnt_d  = cnt_q + 9'd1;
            addr_d = addr_q + 16'd1;
        end

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        // Outputs read as idle for every cycle rst is high, including the
        // first one before the registers have cleared.
        if (rst) begin
            cmd         = 5'd0;
            dat         = 8'd0;
            cmd_valid   = 1'b0;
            wdata_ready = 1'b0;
            req_ready   = 1'b0;
            done        = 1'b0;
        end
    end

    assign cmd_word   = {3'b000, cmd, dat};
    assign busy       = (state_q != IDLE) && !rst;
    assign bytes_done = rst ? 9'd0 : cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bdm_block_sequencer.sv
module tb_bdm_block_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [7:0]  wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        abort;
    logic        busy;
    logic        done;
    logic [8:0]  bytes_done;
    logic [2:0]  dbg_state;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OPC  = 3'd1;
    localparam logic [2:0] S_ALO  = 3'd3;
    localparam logic [2:0] S_DLY  = 3'd5;

    bdm_block_sequencer #(.DELAY_TICKS(8'd16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .cmd_word    (cmd_word),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .bytes_done  (bytes_done),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [7:0]  wq[$];
    logic        stall_mode = 1'b0;
    logic        hold_chk = 1'b0;
    logic [15:0] prev_word = 16'd0;
    logic        wd_xfer = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected five words for one byte.
    task automatic add_byte(input logic op, input logic [15:0] a, input logic [7:0] wd);
        exp_q.push_back(op ? 16'h02C0 : 16'h02E0);
        exp_q.push_back({8'h02, a[15:8]});
        exp_q.push_back({8'h02, a[7:0]});
        if (op) begin
            exp_q.push_back({8'h02, wd});
            exp_q.push_back(16'h0610);
        end else begin
            exp_q.push_back(16'h0610);
            exp_q.push_back(16'h0100);
        end
    endtask

    task automatic check_words(input string tag);
        int n;
        chk($sformatf("%s_nwords", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", cmd_valid, 1);
                chk("hold_word", cmd_word, prev_word);
            end
            hold_chk  = cmd_valid && !cmd_ready;
            prev_word = cmd_word;
            if (cmd_valid && cmd_ready) got_q.push_back(cmd_word);
            if (wdata_valid && wdata_ready) wd_xfer = 1'b1;
            if (done) done_cnt++;
        end
    end

    // ---------------- FIFO-side and write-byte drivers ----------------
    initial begin
        cmd_ready   = 1'b1;
        wdata       = 8'd0;
        wdata_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (wd_xfer) begin
                if (wq.size() != 0) wq.delete(0);
                wdata_valid = 1'b0;
                wd_xfer     = 1'b0;
            end
            cmd_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (!wdata_valid && wq.size() != 0 && (!stall_mode || $urandom_range(0, 2) != 0)) begin
                wdata       = wq[0];
                wdata_valid = 1'b1;
            end
        end
    end

    // ---------------- request driver tasks ----------------
    task automatic send_req(input logic op, input logic [15:0] a, input logic [7:0] len, output int ok);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_len   = len;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Called in the first cycle after acceptance; returns how many cycles
    // after the acceptance cycle done was seen, or -1 on timeout.
    task automatic wait_done(output int cyc);
        int k;
        k = 1;
        cyc = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
            k++;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ok;
        int cyc;
        int d0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 1'b0;
        req_addr = 16'd0;
        req_len = 8'd0;
        abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_word", cmd_word, 16'h0000);
        chk("rst_wdata_ready", wdata_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bytes_done", bytes_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_state", dbg_state, S_IDLE);

        // Single read byte at 0x1234
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        send_req(1'b0, 16'h1234, 8'd1, ok);
        chk("rd1_accept", ok, 1);
        chk("rd1_busy", busy, 1);
        wait_done(cyc);
        chk("rd1_done_latency", cyc, 6);
        exp_q = '{16'h02E0, 16'h0212, 16'h0234, 16'h0610, 16'h0100};
        @(negedge clk);
        check_words("rd1");
        chk("rd1_bytes_done", bytes_done, 1);
        chk("rd1_busy_after", busy, 0);
        chk("rd1_done_cnt", done_cnt - d0, 1);

        // Two write bytes starting at 0xFFFF (address wraps)
        got_q.delete(); exp_q.delete();
        wq.push_back(8'hAA); wq.push_back(8'h55);
        d0 = done_cnt;
        send_req(1'b1, 16'hFFFF, 8'd2, ok);
        chk("wr2_accept", ok, 1);
        wait_done(cyc);
        chk("wr2_done_seen", cyc > 0, 1);
        exp_q = '{16'h02C0, 16'h02FF, 16'h02FF, 16'h02AA, 16'h0610,
                  16'h02C0, 16'h0200, 16'h0200, 16'h0255, 16'h0610};
        @(negedge clk);
        check_words("wr2");
        chk("wr2_bytes_done", bytes_done, 2);
        chk("wr2_done_cnt", done_cnt - d0, 1);

        // len = 0 means 256 bytes
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        send_req(1'b0, 16'hFFF0, 8'd0, ok);
        chk("rd256_accept", ok, 1);
        wait_done(cyc);
        chk("rd256_done_seen", cyc > 0, 1);
        for (int i = 0; i < 256; i++) add_byte(1'b0, 16'hFFF0 + 16'(i), 8'h00);
        @(negedge clk);
        chk("rd256_nwords_1280", got_q.size(), 1280);
        check_words("rd256");
        chk("rd256_bytes_done", bytes_done, 256);
        chk("rd256_done_cnt", done_cnt - d0, 1);

        // Random stalls on both cmd_ready and wdata_valid
        stall_mode = 1'b1;
        got_q.delete(); exp_q.delete();
        wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        send_req(1'b1, 16'h2000, 8'd3, ok);
        chk("wrs_accept", ok, 1);
        wait_done(cyc);
        chk("wrs_done_seen", cyc > 0, 1);
        add_byte(1'b1, 16'h2000, 8'h11);
        add_byte(1'b1, 16'h2001, 8'h22);
        add_byte(1'b1, 16'h2002, 8'h33);
        @(negedge clk);
        check_words("wrs");
        chk("wrs_bytes_done", bytes_done, 3);

        got_q.delete(); exp_q.delete();
        send_req(1'b0, 16'h3000, 8'd2, ok);
        chk("rds_accept", ok, 1);
        wait_done(cyc);
        chk("rds_done_seen", cyc > 0, 1);
        add_byte(1'b0, 16'h3000, 8'h00);
        add_byte(1'b0, 16'h3001, 8'h00);
        @(negedge clk);
        check_words("rds");
        chk("rds_bytes_done", bytes_done, 2);
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abort during the ALO transfer of byte 3
        got_q.delete(); exp_q.delete();
        d0 = done_cnt;
        send_req(1'b0, 16'h4000, 8'd5, ok);
        chk("ab_accept", ok, 1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dbg_state == S_ALO && bytes_done == 9'd2) begin
                ok = 1;
                break;
            end
        end
        chk("ab_reach_alo3", ok, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        // Abort still high in IDLE together with a new request
        req_valid = 1'b1; req_op = 1'b0; req_addr = 16'h0055; req_len = 8'd1;
        @(negedge clk);
        chk("ab_state_idle", dbg_state, S_IDLE);
        chk("ab_busy", busy, 0);
        chk("ab_bytes_done", bytes_done, 2);
        chk("ab_req_ready", req_ready, 1);
        chk("ab_no_done", done_cnt - d0, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("ab_new_state_opc", dbg_state, S_OPC);
        chk("ab_new_bytes_done", bytes_done, 0);
        wait_done(cyc);
        chk("ab_new_done_seen", cyc > 0, 1);
        add_byte(1'b0, 16'h4000, 8'h00);
        add_byte(1'b0, 16'h4001, 8'h00);
        exp_q.push_back(16'h02E0); exp_q.push_back(16'h0240); exp_q.push_back(16'h0202);
        add_byte(1'b0, 16'h0055, 8'h00);
        @(negedge clk);
        check_words("ab");
        chk("ab_done_cnt", done_cnt - d0, 1);

        // Reset pulsed during DLY
        d0 = done_cnt;
        send_req(1'b0, 16'h7777, 8'd3, ok);
        chk("rr_accept", ok, 1);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dbg_state == S_DLY) begin
                ok = 1;
                break;
            end
        end
        chk("rr_reach_dly", ok, 1);
        rst = 1'b1;
        #1;
        chk("rr_cmd_valid", cmd_valid, 0);
        chk("rr_cmd_word", cmd_word, 16'h0000);
        chk("rr_busy", busy, 0);
        chk("rr_done", done, 0);
        chk("rr_bytes_done", bytes_done, 0);
        chk("rr_wdata_ready", wdata_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rr_req_ready", req_ready, 1);
        chk("rr_state_idle", dbg_state, S_IDLE);
        chk("rr_no_done", done_cnt - d0, 0);
        got_q.delete(); exp_q.delete();
        send_req(1'b0, 16'h0001, 8'd1, ok);
        chk("rr_new_accept", ok, 1);
        @(negedge clk);
        chk("rr_new_state_opc", dbg_state, S_OPC);
        chk("rr_new_bytes_done", bytes_done, 0);
        wait_done(cyc);
        chk("rr_new_done_seen", cyc > 0, 1);
        exp_q = '{16'h02E0, 16'h0200, 16'h0201, 16'h0610, 16'h0100};
        @(negedge clk);
        check_words("rr");
        chk("rr_new_bytes_done_end", bytes_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
